// File: rtl/dr32e_predict_ctrl.sv
// Static branch prediction control for the DR32E fetch stage: tracks outstanding
// predictions in a FIFO, checks them at resolve time and drives fetch redirects.
module dr32e_predict_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             predict_en_i,
  input  logic             fetch_valid_i,
  input  logic [31:0]      fetch_pc_i,
  input  logic             fetch_is_branch_i,
  input  logic             fetch_compressed_i,
  input  logic             fetch_accept_i,
  input  logic             predict_taken_i,
  input  logic [31:0]      predict_pc_i,
  output logic             predict_valid_o,
  output logic             fetch_stall_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  input  logic             redirect_ready_i,
  input  logic             resolve_valid_i,
  input  logic [31:0]      resolve_next_pc_i,
  output logic             flush_o,
  output logic [CNT_W-1:0] pred_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic             err_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    PRED_REDIR = 2'd1,
    MISP_REDIR = 2'd2
  } state_e;

  state_e           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      mem [DEPTH];

  logic        full;
  logic        empty;
  logic        run;
  logic        enq;
  logic        enq_taken;
  logic [31:0] enq_pc;
  logic        res;
  logic        mispredict;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign run        = (state == RUN);

  assign predict_valid_o = fetch_valid_i & predict_en_i & ~full & run;
  assign fetch_stall_o   = fetch_valid_i & fetch_is_branch_i & (full | ~run);

  assign enq       = fetch_accept_i & fetch_is_branch_i & ~fetch_stall_o;
  assign enq_taken = predict_taken_i & predict_en_i;
  assign enq_pc    = enq_taken ? predict_pc_i
                               : fetch_pc_i + (fetch_compressed_i ? 32'd2 : 32'd4);

  // A resolve against an empty queue is an error and must not touch the queue.
  assign res        = resolve_valid_i & ~empty;
  assign mispredict = res & (resolve_next_pc_i != mem[rd_ptr]);
  assign flush_o    = mispredict;

  // NOTE: the entry storage has no reset; pointers and occupancy define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= enq_pc;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (res) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, res})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= RUN;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else if (mispredict) begin
      // Mispredict wins over any pending or new predicted-taken redirect.
      state         <= MISP_REDIR;
      redirect_o    <= 1'b1;
      redirect_pc_o <= resolve_next_pc_i;
    end else begin
      case (state)
        RUN: begin
          if (enq && enq_taken) begin
            state         <= PRED_REDIR;
            redirect_o    <= 1'b1;
            redirect_pc_o <= predict_pc_i;
          end
        end
        PRED_REDIR, MISP_REDIR: begin
          if (redirect_ready_i) begin
            state      <= RUN;
            redirect_o <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          redirect_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_cnt_o    <= '0;
      mispred_cnt_o <= '0;
      err_o         <= 1'b0;
    end else begin
      if (enq && (pred_cnt_o != '1))           pred_cnt_o    <= pred_cnt_o + CNT_W'(1);
      if (mispredict && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
      if (resolve_valid_i && empty)            err_o         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dr32e_predict_ctrl.sv
// Directed bench for dr32e_predict_ctrl: one task per scenario, inline comparisons
// against hand-computed values; small counters so saturation is reachable.
module tb_dr32e_predict_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             predict_en_i;
  logic             fetch_valid_i;
  logic [31:0]      fetch_pc_i;
  logic             fetch_is_branch_i;
  logic             fetch_compressed_i;
  logic             fetch_accept_i;
  logic             predict_taken_i;
  logic [31:0]      predict_pc_i;
  logic             predict_valid_o;
  logic             fetch_stall_o;
  logic             redirect_o;
  logic [31:0]      redirect_pc_o;
  logic             redirect_ready_i;
  logic             resolve_valid_i;
  logic [31:0]      resolve_next_pc_i;
  logic             flush_o;
  logic [CNT_W-1:0] pred_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;
  logic             err_o;

  int n_cmp = 0;
  int n_bad = 0;

  dr32e_predict_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .predict_en_i       (predict_en_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_is_branch_i  (fetch_is_branch_i),
    .fetch_compressed_i (fetch_compressed_i),
    .fetch_accept_i     (fetch_accept_i),
    .predict_taken_i    (predict_taken_i),
    .predict_pc_i       (predict_pc_i),
    .predict_valid_o    (predict_valid_o),
    .fetch_stall_o      (fetch_stall_o),
    .redirect_o         (redirect_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_ready_i   (redirect_ready_i),
    .resolve_valid_i    (resolve_valid_i),
    .resolve_next_pc_i  (resolve_next_pc_i),
    .flush_o            (flush_o),
    .pred_cnt_o         (pred_cnt_o),
    .mispred_cnt_o      (mispred_cnt_o),
    .err_o              (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in();
    predict_en_i       = 1'b1;
    fetch_valid_i      = 1'b0;
    fetch_pc_i         = '0;
    fetch_is_branch_i  = 1'b0;
    fetch_compressed_i = 1'b0;
    fetch_accept_i     = 1'b0;
    predict_taken_i    = 1'b0;
    predict_pc_i       = '0;
    redirect_ready_i   = 1'b0;
    resolve_valid_i    = 1'b0;
    resolve_next_pc_i  = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic present(input logic [31:0] pc, input logic comp, input logic taken,
                         input logic [31:0] ppc);
    fetch_valid_i      = 1'b1;
    fetch_is_branch_i  = 1'b1;
    fetch_accept_i     = 1'b1;
    fetch_pc_i         = pc;
    fetch_compressed_i = comp;
    predict_taken_i    = taken;
    predict_pc_i       = ppc;
  endtask

  task automatic resolve(input logic [31:0] npc);
    resolve_valid_i   = 1'b1;
    resolve_next_pc_i = npc;
  endtask

  task automatic test_reset();
    clear_in();
    rst_ni = 1'b0;
    fetch_valid_i = 1'b1;
    #12;
    n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL rst_redirect got %0b want 0", redirect_o); end
    n_cmp++; if (redirect_pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_redirect_pc got %h want 0", redirect_pc_o); end
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL rst_flush got %0b want 0", flush_o); end
    n_cmp++; if (pred_cnt_o !== 4'd0 || mispred_cnt_o !== 4'd0) begin n_bad++; $display("FAIL rst_counters got %0d/%0d want 0/0", pred_cnt_o, mispred_cnt_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0b want 0", err_o); end
    n_cmp++; if (predict_valid_o !== 1'b1) begin n_bad++; $display("FAIL rst_predict_valid got %0b want 1", predict_valid_o); end
    rst_ni = 1'b1;
    clear_in();
    tick();
  endtask

  task automatic test_pred_redirect();
    do_reset();
    present(32'h100, 1'b0, 1'b1, 32'hF0);
    #1;
    n_cmp++; if (predict_valid_o !== 1'b1 || fetch_stall_o !== 1'b0) begin n_bad++; $display("FAIL pr_issue got pv=%0b st=%0b want 1/0", predict_valid_o, fetch_stall_o); end
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'hF0) begin n_bad++; $display("FAIL pr_redirect got %0b/%h want 1/000000f0", redirect_o, redirect_pc_o); end
    n_cmp++; if (pred_cnt_o !== 4'd1) begin n_bad++; $display("FAIL pr_pred_cnt got %0d want 1", pred_cnt_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'hF0) begin n_bad++; $display("FAIL pr_hold%0d got %0b/%h want 1/000000f0", i, redirect_o, redirect_pc_o); end
    end
    present(32'h104, 1'b0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (fetch_stall_o !== 1'b1 || predict_valid_o !== 1'b0) begin n_bad++; $display("FAIL pr_stall got st=%0b pv=%0b want 1/0", fetch_stall_o, predict_valid_o); end
    clear_in();
    redirect_ready_i = 1'b1;
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL pr_handshake got %0b want 0", redirect_o); end
    n_cmp++; if (pred_cnt_o !== 4'd1 || dut.count !== 3'd1) begin n_bad++; $display("FAIL pr_occupancy got cnt=%0d occ=%0d want 1/1", pred_cnt_o, dut.count); end
    resolve(32'hF0);
    #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL pr_resolve_flush got %0b want 0", flush_o); end
    tick();
    clear_in();
    n_cmp++; if (dut.count !== 3'd0 || mispred_cnt_o !== 4'd0) begin n_bad++; $display("FAIL pr_resolved got occ=%0d mis=%0d want 0/0", dut.count, mispred_cnt_o); end
  endtask

  task automatic test_not_taken_correct();
    do_reset();
    present(32'h200, 1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b0 || dut.count !== 3'd1) begin n_bad++; $display("FAIL nt_enq got red=%0b occ=%0d want 0/1", redirect_o, dut.count); end
    resolve(32'h202);
    #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL nt_flush got %0b want 0", flush_o); end
    tick();
    clear_in();
    n_cmp++; if (dut.count !== 3'd0 || mispred_cnt_o !== 4'd0 || redirect_o !== 1'b0) begin n_bad++; $display("FAIL nt_after got occ=%0d mis=%0d red=%0b want 0/0/0", dut.count, mispred_cnt_o, redirect_o); end
  endtask

  task automatic test_mispredict();
    do_reset();
    present(32'h200, 1'b1, 1'b0, 32'h0);
    tick();
    clear_in();
    resolve(32'h300);
    #1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL mp_flush got %0b want 1", flush_o); end
    tick();
    clear_in();
    #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL mp_flush_pulse got %0b want 0", flush_o); end
    n_cmp++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h300) begin n_bad++; $display("FAIL mp_redirect got %0b/%h want 1/00000300", redirect_o, redirect_pc_o); end
    n_cmp++; if (mispred_cnt_o !== 4'd1 || dut.count !== 3'd0) begin n_bad++; $display("FAIL mp_state got mis=%0d occ=%0d want 1/0", mispred_cnt_o, dut.count); end
    redirect_ready_i = 1'b1;
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL mp_handshake got %0b want 0", redirect_o); end
  endtask

  task automatic test_pred_override();
    do_reset();
    present(32'h700, 1'b0, 1'b0, 32'h0);
    tick();
    present(32'h708, 1'b0, 1'b1, 32'h800);
    resolve(32'h704);
    #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL ov_flush0 got %0b want 0", flush_o); end
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h800 || dut.count !== 3'd1) begin n_bad++; $display("FAIL ov_pred got %0b/%h occ=%0d want 1/00000800/1", redirect_o, redirect_pc_o, dut.count); end
    resolve(32'h900);
    #1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL ov_flush1 got %0b want 1", flush_o); end
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h900 || mispred_cnt_o !== 4'd1 || dut.count !== 3'd0) begin n_bad++; $display("FAIL ov_misp got %0b/%h mis=%0d occ=%0d want 1/00000900/1/0", redirect_o, redirect_pc_o, mispred_cnt_o, dut.count); end
    redirect_ready_i = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic test_pred_disabled();
    do_reset();
    present(32'h500, 1'b0, 1'b1, 32'hABC);
    predict_en_i = 1'b0;
    #1;
    n_cmp++; if (predict_valid_o !== 1'b0 || fetch_stall_o !== 1'b0) begin n_bad++; $display("FAIL dis_gate got pv=%0b st=%0b want 0/0", predict_valid_o, fetch_stall_o); end
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b0 || dut.count !== 3'd1 || pred_cnt_o !== 4'd1) begin n_bad++; $display("FAIL dis_enq got red=%0b occ=%0d cnt=%0d want 0/1/1", redirect_o, dut.count, pred_cnt_o); end
    resolve(32'h504);
    #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL dis_resolve got %0b want 0", flush_o); end
    tick();
    clear_in();
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      present(32'h400 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    n_cmp++; if (dut.count !== 3'd4 || pred_cnt_o !== 4'd4) begin n_bad++; $display("FAIL full_fill got occ=%0d cnt=%0d want 4/4", dut.count, pred_cnt_o); end
    present(32'h410, 1'b0, 1'b0, 32'h0);
    resolve(32'h404);
    #1;
    n_cmp++; if (fetch_stall_o !== 1'b1 || predict_valid_o !== 1'b0) begin n_bad++; $display("FAIL full_stall got st=%0b pv=%0b want 1/0", fetch_stall_o, predict_valid_o); end
    tick();
    n_cmp++; if (dut.count !== 3'd3 || pred_cnt_o !== 4'd4) begin n_bad++; $display("FAIL full_pop got occ=%0d cnt=%0d want 3/4", dut.count, pred_cnt_o); end
    present(32'h410, 1'b0, 1'b0, 32'h0);
    resolve(32'h408);
    tick();
    n_cmp++; if (dut.count !== 3'd3 || pred_cnt_o !== 4'd5) begin n_bad++; $display("FAIL full_swap got occ=%0d cnt=%0d want 3/5", dut.count, pred_cnt_o); end
    clear_in();
    present(32'h414, 1'b0, 1'b0, 32'h0);
    tick();
    clear_in();
    fetch_valid_i = 1'b1;
    fetch_is_branch_i = 1'b1;
    #1;
    n_cmp++; if (dut.count !== 3'd4 || fetch_stall_o !== 1'b1) begin n_bad++; $display("FAIL full_refill got occ=%0d st=%0b want 4/1", dut.count, fetch_stall_o); end
    clear_in();
    for (int i = 0; i < 4; i++) begin
      resolve(32'h40C + 32'(4 * i));
      #1;
      n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL full_drain%0d got flush=%0b want 0", i, flush_o); end
      tick();
    end
    clear_in();
    n_cmp++; if (dut.count !== 3'd0 || mispred_cnt_o !== 4'd0 || err_o !== 1'b0) begin n_bad++; $display("FAIL full_empty got occ=%0d mis=%0d err=%0b want 0/0/0", dut.count, mispred_cnt_o, err_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    present(32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 19; i++) begin
      present(32'h600, 1'b0, 1'b0, 32'h0);
      resolve(32'h604);
      tick();
    end
    clear_in();
    n_cmp++; if (pred_cnt_o !== 4'd15 || dut.count !== 3'd1) begin n_bad++; $display("FAIL sat_pred got cnt=%0d occ=%0d want 15/1", pred_cnt_o, dut.count); end
    for (int i = 0; i < 17; i++) begin
      resolve(32'h0);
      tick();
      clear_in();
      redirect_ready_i = 1'b1;
      tick();
      clear_in();
      present(32'h600, 1'b0, 1'b0, 32'h0);
      tick();
      clear_in();
    end
    n_cmp++; if (mispred_cnt_o !== 4'd15 || pred_cnt_o !== 4'd15) begin n_bad++; $display("FAIL sat_misp got mis=%0d cnt=%0d want 15/15", mispred_cnt_o, pred_cnt_o); end
  endtask

  task automatic test_empty_resolve();
    do_reset();
    resolve(32'h1234);
    #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL er_flush got %0b want 0", flush_o); end
    tick();
    clear_in();
    n_cmp++; if (err_o !== 1'b1 || redirect_o !== 1'b0 || dut.count !== 3'd0 || mispred_cnt_o !== 4'd0) begin n_bad++; $display("FAIL er_set got err=%0b red=%0b occ=%0d mis=%0d want 1/0/0/0", err_o, redirect_o, dut.count, mispred_cnt_o); end
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL er_sticky got %0b want 1", err_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL er_clear got %0b want 0", err_o); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    present(32'h200, 1'b1, 1'b0, 32'h0);
    tick();
    clear_in();
    resolve(32'h300);
    tick();
    clear_in();
    n_cmp++; if (redirect_o !== 1'b1 || mispred_cnt_o !== 4'd1 || pred_cnt_o !== 4'd1) begin n_bad++; $display("FAIL rm_setup got red=%0b mis=%0d cnt=%0d want 1/1/1", redirect_o, mispred_cnt_o, pred_cnt_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin n_bad++; $display("FAIL rm_redirect got %0b/%h want 0/00000000", redirect_o, redirect_pc_o); end
    n_cmp++; if (pred_cnt_o !== 4'd0 || mispred_cnt_o !== 4'd0 || flush_o !== 1'b0) begin n_bad++; $display("FAIL rm_counters got %0d/%0d fl=%0b want 0/0/0", pred_cnt_o, mispred_cnt_o, flush_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL rm_abandon got %0b want 0", redirect_o); end
  endtask

  initial begin
    test_reset();
    test_pred_redirect();
    test_not_taken_correct();
    test_mispredict();
    test_pred_override();
    test_pred_disabled();
    test_back_to_back_full();
    test_saturation();
    test_empty_resolve();
    test_reset_mid_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
